prog_loader: RTL and testbench

// Writer side of the CPU instruction-memory interface: receives a program image as a byte

---
 rtl/prog_loader.sv | 144 ++++++++++++++
 tb/tb_prog_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-image loader: parses a length-prefixed byte stream into 14-bit instruction
// words, writes them to program memory and releases the CPU once the checksum verifies.
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err,
    output logic [10:0]       loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_W_HI,
        S_W_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t      state;
    state_t      state_nxt;
    logic        beat;
    logic        take_start;
    logic [7:0]  sum;
    logic [9:0]  index;
    logic [9:0]  last_idx;
    logic [1:0]  len_hi;
    logic [5:0]  hi6;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    // Ready is a pure function of state so it never waits on in_valid.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_W_HI, S_W_LO, S_CSUM: in_ready = 1'b1;
            default:                                    in_ready = 1'b0;
        endcase
    end

    assign beat       = in_valid & in_ready;
    assign take_start = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (beat) state_nxt = (in_data[7:2] != 6'd0) ? S_ERR : S_LEN_LO;
            end
            S_LEN_LO: begin
                if (beat) state_nxt = S_W_HI;
            end
            S_W_HI: begin
                if (beat) state_nxt = (in_data[7:6] != 2'd0) ? S_ERR : S_W_LO;
            end
            S_W_LO: begin
                if (beat) state_nxt = (index == last_idx) ? S_CSUM : S_W_HI;
            end
            S_CSUM: begin
                if (beat) state_nxt = (csum_add(sum, in_data) == 8'd0) ? S_DONE : S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            state     <= state_nxt;
            done      <= (state_nxt == S_DONE);
            err       <= (state_nxt == S_ERR);
            cpu_rst_n <= (state_nxt == S_DONE);
        end
    end

    // Header / parse registers; a fresh start wipes the running sum and word index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum      <= 8'd0;
            index    <= 10'd0;
            last_idx <= 10'd0;
            len_hi   <= 2'd0;
            hi6      <= 6'd0;
        end else if (take_start) begin
            sum   <= 8'd0;
            index <= 10'd0;
        end else if (beat) begin
            sum <= csum_add(sum, in_data);
            case (state)
                S_LEN_HI: len_hi   <= in_data[1:0];
                S_LEN_LO: last_idx <= {len_hi, in_data};
                S_W_HI:   hi6      <= in_data[5:0];
                S_W_LO:   if (index != last_idx) index <= index + 10'd1;
                default:  ;
            endcase
        end
    end

    // Memory write port: one-cycle strobe after each completed word, address wraps freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= BASE;
            wr_data <= '0;
            loaded  <= 11'd0;
        end else begin
            wr_en <= 1'b0;
            if (take_start) begin
                loaded <= 11'd0;
            end else if (beat && (state == S_W_LO)) begin
                wr_en   <= 1'b1;
                wr_addr <= BASE + ADDR_W'(index);
                wr_data <= {hi6, in_data};
                loaded  <= loaded + 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: two instances (base 0 and base 1023) driven in lockstep,
// checked against an image parser model and a write scoreboard.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;

    logic        a_in_ready, a_wr_en, a_cpu_rst_n, a_done, a_err;
    logic [9:0]  a_wr_addr;
    logic [13:0] a_wr_data;
    logic [10:0] a_loaded;
    logic        b_in_ready, b_wr_en, b_cpu_rst_n, b_done, b_err;
    logic [9:0]  b_wr_addr;
    logic [13:0] b_wr_data;
    logic [10:0] b_loaded;

    prog_loader #(.ADDR_W(10), .DATA_W(14), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .cpu_rst_n(a_cpu_rst_n), .done(a_done), .err(a_err), .loaded(a_loaded)
    );

    prog_loader #(.ADDR_W(10), .DATA_W(14), .BASE_ADDR(1023)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .cpu_rst_n(b_cpu_rst_n), .done(b_done), .err(b_err), .loaded(b_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [23:0] obs_a[$];
    logic [23:0] obs_b[$];

    always @(negedge clk) begin
        if (a_wr_en) obs_a.push_back({a_wr_addr, a_wr_data});
        if (b_wr_en) obs_b.push_back({b_wr_addr, b_wr_data});
    end

    logic [7:0]  img[$];
    logic [13:0] exp_words[$];
    int          exp_consumed;
    bit          exp_err;

    // Reference: walk the image by its format rules and predict writes and outcome.
    function automatic void model_parse();
        logic [7:0] b, hi, lo, s;
        int n;
        exp_words.delete();
        b = img[0];
        s = b;
        if (b[7:2] != 6'd0) begin
            exp_consumed = 1;
            exp_err = 1'b1;
            return;
        end
        n = int'({b[1:0], img[1]}) + 1;
        s = s + img[1];
        for (int i = 0; i < n; i++) begin
            hi = img[2 + 2 * i];
            lo = img[3 + 2 * i];
            s = s + hi;
            if (hi[7:6] != 2'd0) begin
                exp_consumed = 3 + 2 * i;
                exp_err = 1'b1;
                return;
            end
            s = s + lo;
            exp_words.push_back({hi[5:0], lo});
        end
        s = s + img[2 + 2 * n];
        exp_consumed = 3 + 2 * n;
        exp_err = (s != 8'd0);
    endfunction

    // mode 0 good, 1 bad checksum, 2 bad LEN_HI, 3 bad HI byte in a random pair
    task automatic build_random(input int n, input int mode);
        logic [9:0] lenv;
        logic [7:0] s, t;
        int k;
        img.delete();
        lenv = 10'(n - 1);
        img.push_back({6'd0, lenv[9:8]});
        img.push_back(lenv[7:0]);
        for (int i = 0; i < n; i++) begin
            img.push_back({2'b00, 6'($urandom)});
            img.push_back(8'($urandom));
        end
        s = 8'd0;
        foreach (img[i]) s = s + img[i];
        img.push_back(8'd0 - s);
        if (mode == 1) begin
            img[img.size() - 1] = img[img.size() - 1] + 8'($urandom_range(1, 255));
        end else if (mode == 2) begin
            t = img[0];
            t = t | (8'h04 << $urandom_range(0, 5));
            img[0] = t;
        end else if (mode == 3) begin
            k = $urandom_range(0, n - 1);
            t = img[2 + 2 * k];
            t[7:6] = 2'($urandom_range(1, 3));
            img[2 + 2 * k] = t;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
        bit ok;
        int g;
        g = (pulse && gap < 1) ? 1 : gap;
        in_valid = 1'b0;
        for (int i = 0; i < g; i++) begin
            if (pulse && i == 0) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (a_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_load(input string name, input bit gaps, input bit mid_start);
        obs_a.delete();
        obs_b.delete();
        model_parse();
        do_start();
        chk({name, ".start_done"}, a_done, 0);
        chk({name, ".start_err"}, a_err, 0);
        chk({name, ".start_cpu_rst_n"}, a_cpu_rst_n, 0);
        chk({name, ".start_loaded"}, a_loaded, 0);
        chk({name, ".start_ready"}, a_in_ready, 1);
        for (int i = 0; i < exp_consumed; i++)
            send_byte(img[i], gaps ? $urandom_range(0, 3) : 0, mid_start && (i == 3));
        chk({name, ".done"}, a_done, !exp_err);
        chk({name, ".err"}, a_err, exp_err);
        chk({name, ".cpu_rst_n"}, a_cpu_rst_n, !exp_err);
        chk({name, ".ready_end"}, a_in_ready, 0);
        chk({name, ".b_done"}, b_done, !exp_err);
        chk({name, ".b_err"}, b_err, exp_err);
        in_valid = 1'b1;
        in_data = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({name, ".done_hold"}, a_done, !exp_err);
        chk({name, ".cpu_rst_n_hold"}, a_cpu_rst_n, !exp_err);
        chk({name, ".loaded"}, a_loaded, exp_words.size());
        chk({name, ".b_loaded"}, b_loaded, exp_words.size());
        chk({name, ".nwrites"}, obs_a.size(), exp_words.size());
        chk({name, ".b_nwrites"}, obs_b.size(), exp_words.size());
        for (int i = 0; i < exp_words.size(); i++) begin
            if (i < obs_a.size()) chk({name, ".wr_a"}, obs_a[i], {10'(i), exp_words[i]});
            if (i < obs_b.size()) chk({name, ".wr_b"}, obs_b[i], {10'(1023 + i), exp_words[i]});
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, ".in_ready"}, a_in_ready, 0);
        chk({name, ".wr_en"}, a_wr_en, 0);
        chk({name, ".wr_addr"}, a_wr_addr, 0);
        chk({name, ".b_wr_addr"}, b_wr_addr, 10'd1023);
        chk({name, ".wr_data"}, a_wr_data, 0);
        chk({name, ".cpu_rst_n"}, a_cpu_rst_n, 0);
        chk({name, ".done"}, a_done, 0);
        chk({name, ".err"}, a_err, 0);
        chk({name, ".loaded"}, a_loaded, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("idle.ready", a_in_ready, 0);
        chk("idle.nwrites", obs_a.size(), 0);

        img = '{8'h00, 8'h01, 8'h28, 8'h05, 8'h00, 8'h00, 8'hD2};
        run_load("t1", 1'b0, 1'b0);
        if (obs_a.size() > 1) begin
            chk("t1.word0", obs_a[0], {10'd0, 14'h2805});
            chk("t1.word1", obs_a[1], {10'd1, 14'h0000});
            chk("t4.wrap0", obs_b[0], {10'd1023, 14'h2805});
            chk("t4.wrap1", obs_b[1], {10'd0, 14'h0000});
        end

        img = '{8'h00, 8'h01, 8'h28, 8'h05, 8'h00, 8'h00, 8'hD3};
        run_load("t2", 1'b0, 1'b0);

        img = '{8'h04, 8'h01, 8'h28, 8'h05, 8'h00, 8'h00, 8'hD2};
        run_load("t3", 1'b0, 1'b0);

        img = '{8'h00, 8'h01, 8'h28, 8'h05, 8'h00, 8'h00, 8'hD2};
        run_load("t5", 1'b1, 1'b1);

        obs_a.delete();
        do_start();
        for (int i = 0; i < 4; i++) send_byte(img[i], 0, 1'b0);
        chk("t6.wr_pulse", a_wr_en, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("t6.async");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6.idle_ready", a_in_ready, 0);
        run_load("t6.reload", 1'b1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            build_random($urandom_range(1, 12), $urandom_range(0, 3));
            run_load($sformatf("rnd%0d", r), 1'b1, r[0]);
        end

        build_random(1, 0);
        run_load("min_len", 1'b1, 1'b0);
        build_random(1024, 0);
        run_load("max_len", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
